logic_shift_unit: RTL and testbench

LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

---
 rtl/logic_shift_unit.sv | 116 +++++++++++
 tb/tb_logic_shift_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/logic_shift_unit.sv
// rtl/logic_shift_unit.sv - multi-cycle bitwise logic and one-bit-per-cycle shift/rotate unit
//
// Ports:
//   clock  in   single clock, rising edge
//   clear  in   synchronous active-high reset
//   start  in   request, sampled only in IDLE
//   op     in   3-bit operation select (AND/OR/XOR/NOT/SHL/SHR/SHRA/ROL)
//   a      in   operand A / shift source
//   b      in   operand B; low SHAMT_W bits are the shift amount
//   busy   out  high while shifting
//   done   out  one-cycle completion pulse
//   z      out  registered result, held until the next completion
module logic_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         kind;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;

  logic [SHAMT_W-1:0] n;
  logic [WIDTH-1:0]   logic_res;
  logic [WIDTH-1:0]   shifted;
  logic               unused_b_hi;

  assign n           = b[SHAMT_W-1:0];
  assign unused_b_hi = ^b[WIDTH-1:SHAMT_W];

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_comb begin
    logic_res = '0;
    case (op[1:0])
      2'b00:   logic_res = a & b;
      2'b01:   logic_res = a | b;
      2'b10:   logic_res = a ^ b;
      default: logic_res = ~a;
    endcase
  end

  // SHRA fills from work's own MSB: that bit never changes during an
  // arithmetic right shift, so it always equals the latched a[WIDTH-1].
  always_comb begin
    shifted = work;
    case (kind)
      2'b00:   shifted = {work[WIDTH-2:0], 1'b0};
      2'b01:   shifted = {1'b0, work[WIDTH-1:1]};
      2'b10:   shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shifted = {work[WIDTH-2:0], work[WIDTH-1]};
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      kind  <= 2'b00;
      work  <= '0;
      cnt   <= '0;
      z     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              z     <= logic_res;
              state <= DONE;
            end else if (n == '0) begin
              z     <= a;
              state <= DONE;
            end else begin
              kind  <= op[1:0];
              work  <= a;
              cnt   <= n;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            z     <= shifted;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_shift_unit.sv
// tb/tb_logic_shift_unit.sv - scoreboard bench for logic_shift_unit
module tb_logic_shift_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z;

  typedef struct {
    logic [31:0] z;
    int          n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;
  logic prev_done = 1'b0;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_XOR = 3'b010, OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100, OP_SHR = 3'b101, OP_SHRA = 3'b110, OP_ROL = 3'b111;

  logic_shift_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z)
  );

  always #5 clock = ~clock;

  // Monitor: pops one expectation per done pulse and checks result and busy length.
  always @(negedge clock) begin
    if (clear) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        total++;
        if (prev_done) begin
          bad++;
          $display("FAIL done_width: done high on consecutive cycles, required single-cycle pulse");
        end
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: z=%08h with no outstanding op", z);
        end else begin
          exp_t e;
          e = q.pop_front();
          total++;
          if (z !== e.z) begin
            bad++;
            $display("FAIL result: z=%08h required %08h", z, e.z);
          end
          total++;
          if (busy_cnt != e.n) begin
            bad++;
            $display("FAIL busy_len: busy cycles=%0d required %0d", busy_cnt, e.n);
          end
        end
        busy_cnt = 0;
      end
    end
    prev_done = done;
  end

  // Drive one op; inputs are scrambled right after the start edge so that
  // any use of post-start inputs shows up as a wrong result.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ez, input int en, input bit hold);
    int  k;
    bit  got;
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    q.push_back('{ez, en});
    @(posedge clock);
    #1;
    op = 3'($urandom);
    a  = $urandom;
    b  = $urandom;
    if (!hold) start = 1'b0;
    k   = 0;
    got = 0;
    for (int i = 0; i < en + 4; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1;
        break;
      end
      k++;
    end
    total++;
    if (!got || k != en) begin
      bad++;
      $display("FAIL latency: op=%0d done_seen=%0d cycles_after_start_edge=%0d required %0d",
               o, got, k, en);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_zero(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 32'h0) begin
      bad++;
      $display("FAIL %s: busy=%b done=%b z=%08h required busy=0 done=0 z=00000000",
               name, busy, done, z);
    end
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clock);
    #1;
    check_idle_zero("reset_state");
    clear = 1'b0;

    issue(OP_AND,  32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 0,  1'b0);
    issue(OP_SHL,  32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 5,  1'b0);
    issue(OP_SHRA, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 31, 1'b0);
    issue(OP_SHR,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 31, 1'b0);
    issue(OP_ROL,  32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 0,  1'b0);
    issue(OP_ROL,  32'h8000_0001, 32'h0000_0024, 32'h0000_0018, 4,  1'b0);
    issue(OP_OR,   32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0, 0,  1'b0);
    issue(OP_NOT,  32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987, 0,  1'b0);

    // Clear during SHIFT at edge S+3: op is discarded, no done pulse.
    op    = OP_SHR;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_000A;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check_idle_zero("clear_mid_shift");
    // First edge after clear accepts the next start.
    issue(OP_XOR, 32'h0000_000F, 32'h0000_00FF, 32'h0000_00F0, 0, 1'b0);
    repeat (3) @(posedge clock);
    #1;

    // Start held high: back-to-back ops with inputs scrambled mid-operation.
    issue(OP_SHL,  32'h0000_0003, 32'h0000_0002, 32'h0000_000C, 2, 1'b1);
    issue(OP_SHRA, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 4, 1'b1);
    issue(OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 1'b1);
    issue(OP_ROL,  32'h1234_5678, 32'h0000_0008, 32'h3456_7812, 8, 1'b1);
    issue(OP_SHR,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0, 1'b0);

    repeat (4) @(posedge clock);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d ops outstanding, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
